// File: rtl/pipeline_skid_register_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
//   Shared types and helpers for the pipeline skid register slice.
//   - skid_state_t : occupancy state (EMPTY/BUSY/FULL = 0/1/2 held beats)
//   - lane_t       : widest supported lane; callers zero-extend into it and
//                    slice their own WIDTH back out
//   - apply_mask() : zeroes one lane when its mask bit is clear
// ---------------------------------------------------------------------------
package pipeline_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam int unsigned LANE_MAX = 64;

    typedef logic [LANE_MAX-1:0] lane_t;

    function automatic lane_t apply_mask(input lane_t lane, input logic en);
        return en ? lane : '0;
    endfunction

endpackage

// File: rtl/pipeline_skid_register_entry.sv
// ---------------------------------------------------------------------------
// skid_entry
//   One storage slot: data + mask + valid, with load enable and clear.
//   Ports:
//     clock    in   rising-edge clock
//     reset    in   asynchronous active-low reset (clears data, mask, valid)
//     i_load   in   capture i_data/i_mask and mark valid
//     i_clear  in   invalidate the slot (wins over i_load; data kept)
//     i_data   in   LANES*WIDTH payload
//     i_mask   in   LANES lane-active bits
//     o_data   out  stored payload (unmasked)
//     o_mask   out  stored mask
//     o_valid  out  slot holds a beat
// ---------------------------------------------------------------------------
module skid_entry #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_load,
    input  logic                   i_clear,
    input  logic [LANES*WIDTH-1:0] i_data,
    input  logic [LANES-1:0]       i_mask,
    output logic [LANES*WIDTH-1:0] o_data,
    output logic [LANES-1:0]       o_mask,
    output logic                   o_valid
);

    logic [LANES*WIDTH-1:0] r_data;
    logic [LANES-1:0]       r_mask;
    logic                   r_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data  <= '0;
            r_mask  <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_mask  <= i_mask;
            r_valid <= 1'b1;
        end
    end

    assign o_data  = r_data;
    assign o_mask  = r_mask;
    assign o_valid = r_valid;

endmodule

// File: rtl/pipeline_skid_register.sv
// ---------------------------------------------------------------------------
// pipeline_skid_register
//   Multi-lane pipeline stage with valid/ready handshake, a 2-entry skid
//   buffer (main + skid), per-lane output masking and synchronous flush.
//   Ports:
//     clock      in   rising-edge clock
//     reset      in   asynchronous active-low reset
//     flush      in   synchronous flush; drops held beats and same-cycle input
//     in_valid   in   upstream beat present
//     in_ready   out  stage can accept (registered: !skid.valid)
//     in_data    in   LANES*WIDTH payload, lane i = [i*WIDTH +: WIDTH]
//     in_mask    in   per-lane active bits
//     out_valid  out  beat presented downstream
//     out_ready  in   downstream accepts
//     out_data   out  main payload with inactive lanes forced to 0
//     out_mask   out  mask of presented beat
//     occupancy  out  held beats: 0, 1 or 2
// ---------------------------------------------------------------------------
module pipeline_skid_register
    import pipeline_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [LANES-1:0]       in_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_mask,
    output logic [1:0]             occupancy
);

    skid_state_t r_state;
    skid_state_t w_state_nxt;

    logic                   w_main_load, w_main_clear, w_main_from_skid;
    logic                   w_skid_load, w_skid_clear;
    logic [LANES*WIDTH-1:0] w_main_din, w_main_data, w_skid_data;
    logic [LANES-1:0]       w_main_min, w_main_mask, w_skid_mask;
    logic                   w_main_valid, w_skid_valid;
    logic                   w_accept, w_emit;
    lane_t                  w_lane;

    assign in_ready  = !w_skid_valid;
    assign w_accept  = in_valid && !w_skid_valid;
    assign w_emit    = w_main_valid && out_ready;

    // Main refills from skid on a FULL drain, otherwise from the input.
    assign w_main_din = w_main_from_skid ? w_skid_data : in_data;
    assign w_main_min = w_main_from_skid ? w_skid_mask : in_mask;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_main_clear     = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        if (flush) begin
            w_state_nxt  = EMPTY;
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_main_load = 1'b1;
                        w_state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    if (w_accept && w_emit) begin
                        w_main_load = 1'b1;
                    end else if (w_accept) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = FULL;
                    end else if (w_emit) begin
                        w_main_clear = 1'b1;
                        w_state_nxt  = EMPTY;
                    end
                end
                FULL: begin
                    if (w_emit) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clear     = 1'b1;
                        w_state_nxt      = BUSY;
                    end
                end
                default: begin
                    w_state_nxt  = EMPTY;
                    w_main_clear = 1'b1;
                    w_skid_clear = 1'b1;
                end
            endcase
        end
    end

    skid_entry #(.WIDTH(WIDTH), .LANES(LANES)) u_main (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_din),
        .i_mask  (w_main_min),
        .o_data  (w_main_data),
        .o_mask  (w_main_mask),
        .o_valid (w_main_valid)
    );

    skid_entry #(.WIDTH(WIDTH), .LANES(LANES)) u_skid (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (in_data),
        .i_mask  (in_mask),
        .o_data  (w_skid_data),
        .o_mask  (w_skid_mask),
        .o_valid (w_skid_valid)
    );

    // Mask applied on the output path only; stored data stays whole.
    always_comb begin
        out_data = '0;
        w_lane   = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_lane = apply_mask(lane_t'(w_main_data[i*WIDTH +: WIDTH]), w_main_mask[i]);
            out_data[i*WIDTH +: WIDTH] = w_lane[WIDTH-1:0];
        end
    end

    assign out_valid = w_main_valid;
    assign out_mask  = w_main_mask;
    assign occupancy = r_state;

endmodule
